// File: rtl/rf_pkg.sv
// Shared helpers and default sizing for the scoreboarded register file.
package rf_pkg;

  // Ceiling log2, usable in constant expressions for port and counter widths.
  function automatic int clog2(input int value);
    int result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_MAXP   = 3;
  localparam int DEF_AW     = clog2(DEF_NREGS);
  localparam int DEF_PW     = clog2(DEF_MAXP + 1);

endpackage

// File: rtl/rf_pend_counter.sv
// Pending-write counter for one architectural register. Counts reservations
// in and releases out, clears on flush, and flags a release seen at zero.
module rf_pend_counter
  import rf_pkg::*;
#(
  parameter  int MAXP = DEF_MAXP,
  localparam int PW   = clog2(MAXP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [PW-1:0] cnt,
  output logic          full,
  output logic          zero,
  output logic          underflow
);

  logic dec_ok;
  logic inc_ok;

  assign zero      = (cnt == '0);
  assign full      = (cnt == PW'(MAXP));
  assign underflow = dec & zero;
  // A release at zero is dropped; the count never goes negative.
  assign dec_ok    = dec & ~zero;
  // An increment at full only lands when a release frees a slot this cycle.
  assign inc_ok    = inc & (~full | dec_ok);

  // Count update: flush wins, simultaneous reserve and release cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_ok && !dec_ok) begin
      cnt <= cnt + PW'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt <= cnt - PW'(1);
    end
  end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with a per-register pending-write scoreboard shared by the
// decode (reserve) and execute (writeback/release) stages. Two combinational
// read ports report data and busy, with optional writeback forwarding.
module scoreboard_regfile
  import rf_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int MAXP     = DEF_MAXP,
  parameter  bit BYPASS   = 1'b1,
  parameter  bit ZERO_REG = 1'b0,
  localparam int AW       = clog2(NREGS),
  localparam int PW       = clog2(MAXP + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rd_addr1,
  input  logic [AW-1:0]     rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  output logic              rsv_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_release,
  output logic              wb_done,
  input  logic              flush,
  output logic              err_underflow
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [PW-1:0]     cnt  [NREGS];
  logic [NREGS-1:0]  inc_vec;
  logic [NREGS-1:0]  dec_vec;
  logic [NREGS-1:0]  full_vec;
  logic [NREGS-1:0]  zero_vec;
  logic [NREGS-1:0]  uf_vec;
  logic [NREGS-1:0]  rel_hit;
  logic [NREGS-1:0]  busy_vec;
  logic              wb_write;

  // A reservation is possible below the limit, or at the limit when a
  // release on the same register frees a slot in this same cycle.
  assign rsv_ready = ~full_vec[rsv_addr] | rel_hit[rsv_addr];
  assign wb_write  = wb_valid & ~(ZERO_REG & (wb_addr == '0));

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    // Register 0 is inert when hardwired to zero: no reserve, no release.
    localparam bit IS_ZERO = ZERO_REG && (gi == 0);

    assign inc_vec[gi] = !IS_ZERO && rsv_valid && rsv_ready && (rsv_addr == AW'(gi));
    assign dec_vec[gi] = !IS_ZERO && wb_valid && wb_release && (wb_addr == AW'(gi));
    assign rel_hit[gi] = dec_vec[gi] & ~zero_vec[gi];

    rf_pend_counter #(
      .MAXP (MAXP)
    ) u_pend (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_vec[gi]),
      .dec       (dec_vec[gi]),
      .clr       (flush),
      .cnt       (cnt[gi]),
      .full      (full_vec[gi]),
      .zero      (zero_vec[gi]),
      .underflow (uf_vec[gi])
    );

    // With forwarding, a register whose last pending write retires this
    // cycle already reads as not busy; same-cycle reservations never count.
    assign busy_vec[gi] = IS_ZERO ? 1'b0 :
                          BYPASS  ? ((cnt[gi] - PW'(rel_hit[gi])) != '0) :
                                    !zero_vec[gi];
  end

  assign rd_busy1 = busy_vec[rd_addr1];
  assign rd_busy2 = busy_vec[rd_addr2];

  // Read port 1: array value, overridden by forwarding, then by zero register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rd_data1 = regs[rd_addr1];
    if (BYPASS && wb_valid && (wb_addr == rd_addr1)) rd_data1 = wb_data;
    if (ZERO_REG && (rd_addr1 == '0)) rd_data1 = '0;
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (BYPASS && wb_valid && (wb_addr == rd_addr2)) rd_data2 = wb_data;
    if (ZERO_REG && (rd_addr2 == '0)) rd_data2 = '0;
  end

  // Register array write; contents survive flush but not reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the array is reset because reads after reset must return 0; this keeps it in flops, not RAM.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_write) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      regs[wb_addr] <= wb_data;
    end
  end

  // Writeback completion pulse and sticky underflow error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_done       <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      wb_done       <= wb_valid;
      err_underflow <= err_underflow | (|uf_vec);
    end
  end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Self-checking bench: two instances (forwarding/no zero register, and
// no forwarding/zero register) driven in lockstep and compared against a
// behavioural model holding plain integer register values and pending counts.
module tb_scoreboard_regfile;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AB = 3;
  localparam int MP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AB-1:0] rd_addr1, rd_addr2, rsv_addr, wb_addr;
  logic          rsv_valid, wb_valid, wb_release, flush;
  logic [DW-1:0] wb_data;

  logic [DW-1:0] a_d1, a_d2, z_d1, z_d2;
  logic          a_b1, a_b2, a_rdy, a_done, a_err;
  logic          z_b1, z_b2, z_rdy, z_done, z_err;

  int total = 0;
  int bad   = 0;

  // Model state: index 0 = forwarding config, index 1 = zero-register config.
  int mregs [2][NR];
  int mpend [2][NR];
  bit merr  [2];
  bit mdone;

  always #5 clk = ~clk;

  scoreboard_regfile #(.DATA_W(DW), .NREGS(NR), .MAXP(MP), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(a_d1), .rd_data2(a_d2),
    .rd_busy1(a_b1), .rd_busy2(a_b2),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(a_rdy),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_release(wb_release),
    .wb_done(a_done), .flush(flush), .err_underflow(a_err)
  );

  scoreboard_regfile #(.DATA_W(DW), .NREGS(NR), .MAXP(MP), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(z_d1), .rd_data2(z_d2),
    .rd_busy1(z_b1), .rd_busy2(z_b2),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(z_rdy),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_release(wb_release),
    .wb_done(z_done), .flush(flush), .err_underflow(z_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit has_bp(input int c); return c == 0; endfunction
  function automatic bit has_zr(input int c); return c == 1; endfunction

  function automatic int exp_data(input int c, input int a);
    if (has_zr(c) && a == 0) return 0;
    if (has_bp(c) && wb_valid && int'(wb_addr) == a) return int'(wb_data);
    return mregs[c][a];
  endfunction

  function automatic bit exp_busy(input int c, input int a);
    int p;
    if (has_zr(c) && a == 0) return 1'b0;
    p = mpend[c][a];
    if (has_bp(c) && wb_valid && wb_release && int'(wb_addr) == a && p > 0) p = p - 1;
    return p != 0;
  endfunction

  function automatic bit exp_ready(input int c);
    int p;
    p = mpend[c][rsv_addr];
    return (p < MP) || (wb_valid && wb_release && wb_addr == rsv_addr && p > 0);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < NR; i++) begin
        mregs[c][i] = 0;
        mpend[c][i] = 0;
      end
      merr[c] = 1'b0;
    end
    mdone = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs.
  task automatic model_step();
    for (int c = 0; c < 2; c++) begin
      bit acc, rel, rel_ok;
      acc    = rsv_valid && exp_ready(c) && !(has_zr(c) && rsv_addr == 0);
      rel    = wb_valid && wb_release && !(has_zr(c) && wb_addr == 0);
      rel_ok = rel && mpend[c][wb_addr] > 0;
      if (rel && mpend[c][wb_addr] == 0) merr[c] = 1'b1;
      if (flush) begin
        for (int i = 0; i < NR; i++) mpend[c][i] = 0;
      end else begin
        if (acc)    mpend[c][rsv_addr] = mpend[c][rsv_addr] + 1;
        if (rel_ok) mpend[c][wb_addr]  = mpend[c][wb_addr] - 1;
      end
      if (wb_valid && !(has_zr(c) && wb_addr == 0)) mregs[c][wb_addr] = int'(wb_data);
    end
    mdone = wb_valid;
  endtask

  task automatic check_all();
    check("byp.d1",   a_d1,   exp_data(0, rd_addr1));
    check("byp.d2",   a_d2,   exp_data(0, rd_addr2));
    check("byp.b1",   a_b1,   exp_busy(0, rd_addr1));
    check("byp.b2",   a_b2,   exp_busy(0, rd_addr2));
    check("byp.rdy",  a_rdy,  exp_ready(0));
    check("byp.done", a_done, mdone);
    check("byp.err",  a_err,  merr[0]);
    check("zr.d1",    z_d1,   exp_data(1, rd_addr1));
    check("zr.d2",    z_d2,   exp_data(1, rd_addr2));
    check("zr.b1",    z_b1,   exp_busy(1, rd_addr1));
    check("zr.b2",    z_b2,   exp_busy(1, rd_addr2));
    check("zr.rdy",   z_rdy,  exp_ready(1));
    check("zr.done",  z_done, mdone);
    check("zr.err",   z_err,  merr[1]);
  endtask

  // Entered at a falling edge with inputs already set; leaves at the next one.
  task automatic cycle();
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rsv_valid = 1'b0; wb_valid = 1'b0; wb_release = 1'b0; flush = 1'b0;
  endtask

  task automatic reserve(input int a);
    idle(); rsv_valid = 1'b1; rsv_addr = AB'(a); cycle();
  endtask

  task automatic writeback(input int a, input int d, input bit rel);
    idle(); wb_valid = 1'b1; wb_addr = AB'(a); wb_data = DW'(d); wb_release = rel; cycle();
  endtask

  initial begin
    rst = 1'b1; idle();
    rd_addr1 = '0; rd_addr2 = '0; rsv_addr = '0; wb_addr = '0; wb_data = '0;
    model_reset();
    #1;
    check("rst.data", a_d1, 16'h0000);
    check("rst.busy", a_b1, 1'b0);
    check("rst.rdy",  a_rdy, 1'b1);
    check("rst.done", a_done, 1'b0);
    check("rst.err",  a_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reserve then write with forwarding.
    rd_addr1 = 3'd2; rd_addr2 = 3'd7;
    reserve(2);
    idle(); #1; check("rsv.busy", a_b1, 1'b1); cycle();
    idle(); wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 16'hBEEF; wb_release = 1'b1;
    #1;
    check("fwd.data", a_d1, 16'hBEEF);
    check("fwd.busy", a_b1, 1'b0);
    check("nofwd.busy", z_b1, 1'b1);
    cycle();
    idle(); #1; check("wb.done", a_done, 1'b1); cycle();

    // Saturation at MAXP and release-assisted fourth reservation.
    rd_addr1 = 3'd5;
    for (int i = 0; i < MP; i++) reserve(5);
    idle(); rsv_valid = 1'b1; rsv_addr = 3'd5;
    #1; check("sat.rdy", a_rdy, 1'b0); cycle();
    wb_valid = 1'b1; wb_addr = 3'd5; wb_data = 16'h0055; wb_release = 1'b1;
    #1; check("sat.rdy_rel", a_rdy, 1'b1); cycle();
    for (int i = 0; i < MP; i++) writeback(5, 16'h0500 + i, 1'b1);
    idle(); #1; check("sat.drained", a_b1, 1'b0); cycle();

    // Underflow: release on an idle register still writes data.
    rd_addr1 = 3'd1;
    writeback(1, 16'h1111, 1'b1);
    idle(); #1;
    check("uf.err", a_err, 1'b1);
    check("uf.data", a_d1, 16'h1111);
    cycle();

    // Zero register (second instance).
    rd_addr1 = 3'd0;
    idle(); rsv_valid = 1'b1; rsv_addr = 3'd0; wb_valid = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
    #1;
    check("zr.data0", z_d1, 16'h0000);
    check("zr.busy0", z_b1, 1'b0);
    check("zr.rdy0",  z_rdy, 1'b1);
    cycle();
    idle(); #1;
    check("zr.done0", z_done, 1'b1);
    check("zr.hold0", z_d1, 16'h0000);
    cycle();

    // Flush overrides a simultaneous reserve; data is kept.
    writeback(4, 16'h4444, 1'b0);
    writeback(6, 16'h6666, 1'b0);
    reserve(4); reserve(4); reserve(6);
    rd_addr1 = 3'd4; rd_addr2 = 3'd6;
    idle(); flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 3'd4; cycle();
    idle(); #1;
    check("fl.busy4", a_b1, 1'b0);
    check("fl.busy6", a_b2, 1'b0);
    check("fl.data4", a_d1, 16'h4444);
    check("fl.data6", a_d2, 16'h6666);
    cycle();

    // Asynchronous reset in the middle of a cycle.
    rd_addr1 = 3'd3;
    reserve(3); reserve(3);
    writeback(3, 16'h1234, 1'b0);
    idle(); rsv_addr = 3'd3; cycle();
    idle(); #2; rst = 1'b1; #1;
    check("arst.data", a_d1, 16'h0000);
    check("arst.busy", a_b1, 1'b0);
    check("arst.rdy",  a_rdy, 1'b1);
    check("arst.err",  a_err, 1'b0);
    model_reset();
    @(negedge clk); rst = 1'b0;

    // Randomized traffic, re-reset between blocks so underflow is re-armed.
    for (int blk = 0; blk < 4; blk++) begin
      rst = 1'b1; idle(); model_reset();
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 500; n++) begin
        rsv_valid  = ($urandom_range(0, 1) == 1);
        rsv_addr   = AB'($urandom_range(0, NR - 1));
        wb_valid   = ($urandom_range(0, 1) == 1);
        wb_addr    = AB'($urandom_range(0, NR - 1));
        wb_data    = DW'($urandom);
        wb_release = ($urandom_range(0, 3) != 0);
        flush      = ($urandom_range(0, 31) == 0);
        rd_addr1   = AB'($urandom_range(0, NR - 1));
        rd_addr2   = AB'($urandom_range(0, NR - 1));
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scoreboard_regfile.md
Name: scoreboard_regfile

Overview:
- Parametrised successor to the pipeline's register file, shared by the decode and execute stages.
- Provides two combinational read ports with per-register busy (in-use) status.
- Decode reserves a destination register at issue; execute writes back and releases the reservation.
- New over the current register file: configurable width and depth, a pending-write counter per register (multiple in-flight writes), write-to-read bypass, hardwired zero register, flush, and an underflow error flag.

Parameters:
- DATA_W, 16, register data width in bits
- NREGS, 8, number of architectural registers (power of two, 2..64)
- MAXP, 3, maximum outstanding reservations per register (1..15)
- BYPASS, 1, 1 = same-cycle writeback is forwarded to the read ports and busy is cleared; 0 = no forwarding
- ZERO_REG, 0, 1 = register 0 always reads 0, and reserve/write to it are ignored

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr1  in  AW=clog2(NREGS)  read port 1 address
- rd_addr2  in  AW  read port 2 address
- rd_data1  out  DATA_W  read port 1 data
- rd_data2  out  DATA_W  read port 2 data
- rd_busy1  out  1  register at rd_addr1 has a pending write
- rd_busy2  out  1  register at rd_addr2 has a pending write
- rsv_valid  in  1  reserve request from decode
- rsv_addr  in  AW  destination register to reserve
- rsv_ready  out  1  reservation can be accepted this cycle
- wb_valid  in  1  writeback from execute
- wb_addr  in  AW  writeback register
- wb_data  in  DATA_W  writeback value
- wb_release  in  1  decrement the pending count on this writeback
- wb_done  out  1  one-cycle pulse, the cycle after a writeback is accepted
- flush  in  1  synchronous: clear all pending counts
- err_underflow  out  1  sticky: a release was seen on a register with count 0

Behaviour:
- Reset (asynchronous, rst=1):
  - all registers, pending counts, wb_done and err_underflow clear to 0 immediately
  - rsv_ready=1 while rst is asserted
- State:
  - regs[NREGS] of DATA_W
  - pend[NREGS] of PW=clog2(MAXP+1) bits
- Read path, combinational, zero latency:
  - rd_data = regs[addr]
  - if BYPASS=1 and wb_valid and wb_addr==addr, rd_data = wb_data
  - if ZERO_REG=1 and addr==0, rd_data = 0 and busy = 0
- Busy:
  - BYPASS=0: busy = (pend[addr]!=0)
  - BYPASS=1: busy = (pend[addr] - rel_hit)!=0, where rel_hit = wb_valid & wb_release & (wb_addr==addr) & pend[addr]!=0
  - A same-cycle reservation does not affect busy in that cycle; the issuing instruction reads pre-reservation state.
- Reservation:
  - rsv_ready = (pend[rsv_addr] < MAXP) | rel_hit_on_rsv_addr
  - accepted when rsv_valid & rsv_ready; pend increments at the next posedge
  - rsv_valid with rsv_ready=0: no state change; decode must hold and stall
- Writeback, accepted whenever wb_valid=1 (never back-pressured):
  - regs[wb_addr] <= wb_data at posedge
  - if wb_release and pend!=0, pend decrements
  - if wb_release and pend==0: pend stays 0, err_underflow <= 1; the data write still occurs
- Simultaneous reserve and release on the same register: pend is unchanged.
- Reserve and release on different registers: both updates apply.
- wb_done <= wb_valid (registered), including writes ignored because of ZERO_REG.
- flush:
  - all pend <= 0 at posedge; register contents are kept
  - flush overrides a reserve in the same cycle; a writeback in the same cycle still writes data
  - err_underflow is not set by flush
- err_underflow is cleared only by rst.
- Width rules: pend arithmetic is PW bits and saturating is impossible by construction (rsv_ready gating).

Decomposition:
- Package rf_pkg:
  - function clog2
  - localparams AW and PW derived from the parameters
- Sub-module rf_pend_counter, one instance per register:
  - inputs inc, dec, clr
  - outputs cnt, full (cnt==MAXP), zero
  - owns the increment/decrement/clear and underflow detection
- The top level holds the register array, read muxes, bypass, and the OR of the per-counter underflow signals.

Test Plan:
- Reset mid-operation: pend[3]=2, regs[3]=0x1234, assert rst asynchronously between clock edges -> rd_data for addr 3 = 0 and rd_busy = 0 immediately; rsv_ready=1.
- Reserve then write: reserve r2; next cycle read r2 -> rd_busy=1; writeback r2=0xBEEF with release, BYPASS=1 -> same cycle rd_data=0xBEEF and rd_busy=0; wb_done=1 the cycle after.
- Saturation: reserve r5 three times with MAXP=3 -> rsv_ready=0 for r5, and a 4th reserve is ignored; a release on r5 in the same cycle as the 4th reserve -> accepted, pend stays 3.
- Underflow: writeback r1 with release while pend[1]=0 -> regs[1] updated, pend[1]=0, err_underflow=1 and it stays set until rst.
- Zero register, ZERO_REG=1: reserve r0 and write r0=0xFFFF -> rd_data=0, rd_busy=0, rsv_ready=1; wb_done still pulses.
- Flush: pend[4]=2 and pend[6]=1; flush with a simultaneous reserve of r4 -> all busy=0 next cycle, and register values are unchanged.
